// File: rtl/lsw_pkg.sv
// Shared types for the load switch sequencer: FSM states, break-before-make step
// encoding, current polarity constants and switch-pair bit mapping (FAULT only with LSEQ_SHORT_FAULT_EN).
package lsw_pkg;

    localparam logic POS = 1'b1;
    localparam logic NEG = 1'b0;

`ifdef LSEQ_SHORT_FAULT_EN
    typedef enum logic [2:0] {OPEN, CLOSE, STEADY, BRK1, MK1, BRK2, DROP, FAULT} state_t;
`else
    typedef enum logic [2:0] {OPEN, CLOSE, STEADY, BRK1, MK1, BRK2, DROP} state_t;
`endif

    typedef enum logic [2:0] {
        STEP_NONE,
        STEP_CLR_H_OLD,
        STEP_CLR_L_OLD,
        STEP_SET_H_NEW,
        STEP_SET_L_NEW,
        STEP_SET_PAIR_NEW
    } step_t;

    // Phase 0..3 of a load swap; a drop reuses phases 0 and 2 (the two clears).
    function automatic step_t seq_step(input logic sign, input logic [1:0] phase);
        step_t step;
        step = STEP_NONE;
        case (phase)
            2'd0: step = (sign == POS) ? STEP_CLR_L_OLD : STEP_CLR_H_OLD;
            2'd1: step = (sign == POS) ? STEP_SET_H_NEW : STEP_SET_L_NEW;
            2'd2: step = (sign == NEG) ? STEP_CLR_L_OLD : STEP_CLR_H_OLD;
            2'd3: step = (sign == NEG) ? STEP_SET_H_NEW : STEP_SET_L_NEW;
        endcase
        return step;
    endfunction

    // Load 1 owns the most significant pair.
    function automatic int unsigned h_bit(input int unsigned nloads, input int unsigned k);
        return 2 * (nloads - k) + 1;
    endfunction

    function automatic int unsigned l_bit(input int unsigned nloads, input int unsigned k);
        return 2 * (nloads - k);
    endfunction

endpackage

// File: rtl/lsw_dwell_timer.sv
// Dwell down-counter: load presets DWELL-1, expire is high when the count sits at zero,
// so a state entered with load is held exactly DWELL cycles.
module lsw_dwell_timer #(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(DWELL - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/load_switch_seq.sv
// Break-before-make load switch sequencer with dwell-timed steps.
// Short-circuit latching fault is enabled by defining LSEQ_SHORT_FAULT_EN.
//
// state  | meaning
// OPEN   | all switches open, waiting for a target
// CLOSE  | dwell before closing the target pair
// STEADY | one pair fully closed, new requests evaluated
// BRK1   | first switch of old pair opened
// MK1    | first switch of new pair closed
// BRK2   | old pair fully open, waiting to close second new switch
// DROP   | first switch of old pair opened, going to OPEN
// FAULT  | short seen, all open until reset
module load_switch_seq
    import lsw_pkg::*;
#(
    parameter int NLOADS = 3,
    parameter int DWELL  = 2,
    localparam int SEL_W = $clog2(NLOADS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SEL_W-1:0]    DesiredLoad,
    input  logic                CurrentSign,
    input  logic                Short,
    output logic [2*NLOADS-1:0] Sout,
    output logic [SEL_W-1:0]    ActiveLoad,
    output logic                Busy,
    output logic                Fault
);

    localparam int SW_W  = 2 * NLOADS;
    localparam int IDX_W = $clog2(SW_W);
    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NLOADS);

    state_t            state_q, state_nxt;
    logic [SW_W-1:0]   sout_q, sout_nxt;
    logic [SEL_W-1:0]  active_q, active_nxt;
    logic [SEL_W-1:0]  target_q, target_nxt;
    logic              sign_q, sign_nxt;
    step_t             step;
    logic              tmr_load;
    logic              tmr_expire;
    logic              req_ok;
    logic [IDX_W-1:0]  h_old, l_old, h_new, l_new;

    lsw_dwell_timer #(.DWELL(DWELL)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .expire (tmr_expire)
    );

    assign h_old = IDX_W'(h_bit(NLOADS, 32'(active_q)));
    assign l_old = IDX_W'(l_bit(NLOADS, 32'(active_q)));
    assign h_new = IDX_W'(h_bit(NLOADS, 32'(target_q)));
    assign l_new = IDX_W'(l_bit(NLOADS, 32'(target_q)));

    assign req_ok = (DesiredLoad != '0) && (DesiredLoad <= MAX_SEL) && (DesiredLoad != active_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= OPEN;
            sout_q   <= '0;
            active_q <= '0;
            target_q <= '0;
            sign_q   <= POS;
        end else begin
            state_q  <= state_nxt;
            sout_q   <= sout_nxt;
            active_q <= active_nxt;
            target_q <= target_nxt;
            sign_q   <= sign_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        sout_nxt   = sout_q;
        active_nxt = active_q;
        target_nxt = target_q;
        sign_nxt   = sign_q;
        step       = STEP_NONE;
        tmr_load   = 1'b0;

        case (state_q)
            OPEN: begin
                sout_nxt = '0;
                if (req_ok) begin
                    target_nxt = DesiredLoad;
                    tmr_load   = 1'b1;
                    state_nxt  = CLOSE;
                end
            end
            CLOSE: begin
                if (tmr_expire) begin
                    step       = STEP_SET_PAIR_NEW;
                    active_nxt = target_q;
                    state_nxt  = STEADY;
                end
            end
            STEADY: begin
                if (DesiredLoad == '0) begin
                    sign_nxt  = CurrentSign;
                    step      = seq_step(CurrentSign, 2'd0);
                    tmr_load  = 1'b1;
                    state_nxt = DROP;
                end else if (req_ok) begin
                    target_nxt = DesiredLoad;
                    sign_nxt   = CurrentSign;
                    step       = seq_step(CurrentSign, 2'd0);
                    tmr_load   = 1'b1;
                    state_nxt  = BRK1;
                end
            end
            BRK1: begin
                if (tmr_expire) begin
                    step      = seq_step(sign_q, 2'd1);
                    tmr_load  = 1'b1;
                    state_nxt = MK1;
                end
            end
            MK1: begin
                if (tmr_expire) begin
                    step      = seq_step(sign_q, 2'd2);
                    tmr_load  = 1'b1;
                    state_nxt = BRK2;
                end
            end
            BRK2: begin
                if (tmr_expire) begin
                    step       = seq_step(sign_q, 2'd3);
                    active_nxt = target_q;
                    state_nxt  = STEADY;
                end
            end
            DROP: begin
                if (tmr_expire) begin
                    step       = seq_step(sign_q, 2'd2);
                    active_nxt = '0;
                    state_nxt  = OPEN;
                end
            end
`ifdef LSEQ_SHORT_FAULT_EN
            FAULT: begin
                sout_nxt   = '0;
                active_nxt = '0;
            end
`endif
            default: state_nxt = OPEN;
        endcase

        case (step)
            STEP_CLR_H_OLD:    sout_nxt[h_old] = 1'b0;
            STEP_CLR_L_OLD:    sout_nxt[l_old] = 1'b0;
            STEP_SET_H_NEW:    sout_nxt[h_new] = 1'b1;
            STEP_SET_L_NEW:    sout_nxt[l_new] = 1'b1;
            STEP_SET_PAIR_NEW: begin
                sout_nxt[h_new] = 1'b1;
                sout_nxt[l_new] = 1'b1;
            end
            default: ;
        endcase

`ifdef LSEQ_SHORT_FAULT_EN
        // A short overrides any pending step or request on the same edge.
        if (Short) begin
            state_nxt  = FAULT;
            sout_nxt   = '0;
            active_nxt = '0;
            tmr_load   = 1'b0;
        end
`endif
    end

    assign Sout       = sout_q;
    assign ActiveLoad = active_q;
    assign Busy       = (state_q == CLOSE) || (state_q == BRK1) || (state_q == MK1) ||
                        (state_q == BRK2)  || (state_q == DROP);

`ifdef LSEQ_SHORT_FAULT_EN
    assign Fault = (state_q == FAULT);
`else
    logic unused_short;
    assign unused_short = Short;
    assign Fault        = 1'b0;
`endif

endmodule

// File: tb/tb_load_switch_seq.sv
// Bench for load_switch_seq in two configurations (3 loads / dwell 2, 4 loads / dwell 3):
// directed sequences with literal expectations plus random stimulus against a pattern-schedule model.
module tb_load_switch_seq;

`ifdef LSEQ_SHORT_FAULT_EN
    localparam bit FEN = 1'b1;
`else
    localparam bit FEN = 1'b0;
`endif

    typedef struct {
        logic [7:0] so;
        logic [2:0] al;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_v   [2];
    logic [2:0] dl_v    [2];
    logic       sign_v  [2];
    logic       short_v [2];
    wire  [7:0] sout_v  [2];
    wire  [2:0] act_v   [2];
    wire        busy_v  [2];
    wire        fault_v [2];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [7:0] hm(input int n, input int k);
        return 8'(1) << (2 * (n - k) + 1);
    endfunction

    function automatic logic [7:0] lm(input int n, input int k);
        return 8'(1) << (2 * (n - k));
    endfunction

    task automatic cmp(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cfg%0d: got %0h want %0h at %0t", name, g, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int N  = (g == 0) ? 3 : 4;
        localparam int DW = (g == 0) ? 2 : 3;
        localparam int SW = $clog2(N + 1);

        wire [2*N-1:0] so;
        wire [SW-1:0]  al;

        load_switch_seq #(.NLOADS(N), .DWELL(DW)) dut (
            .clk         (clk),
            .rst         (rst_v[g]),
            .DesiredLoad (dl_v[g][SW-1:0]),
            .CurrentSign (sign_v[g]),
            .Short       (short_v[g]),
            .Sout        (so),
            .ActiveLoad  (al),
            .Busy        (busy_v[g]),
            .Fault       (fault_v[g])
        );

        assign sout_v[g] = 8'(so);
        assign act_v[g]  = 3'(al);

        // Model: a request expands into a list of future switch patterns, one every DW cycles.
        logic [7:0] m_so    = '0;
        logic [2:0] m_al    = '0;
        logic       m_fault = 1'b0;
        ev_t        q[$];
        int         wcnt    = 0;

        always @(posedge clk) begin
            int d;
            logic s;
            logic [7:0] p1, p2, p3;
            d = int'(dl_v[g][SW-1:0]);
            s = sign_v[g];
            if (!rst_v[g]) begin
                m_so = '0; m_al = '0; m_fault = 1'b0; q.delete(); wcnt = 0;
            end else if (FEN && short_v[g]) begin
                m_so = '0; m_al = '0; m_fault = 1'b1; q.delete();
            end else if (m_fault) begin
                m_so = '0;
            end else if (q.size() > 0) begin
                wcnt--;
                if (wcnt == 0) begin
                    m_so = q[0].so;
                    m_al = q[0].al;
                    void'(q.pop_front());
                    wcnt = DW;
                end
            end else if (m_al == 0) begin
                if (d >= 1 && d <= N) begin
                    q.push_back('{hm(N, d) | lm(N, d), 3'(d)});
                    wcnt = DW;
                end
            end else if (d == 0) begin
                m_so = m_so & (s ? ~lm(N, int'(m_al)) : ~hm(N, int'(m_al)));
                q.push_back('{8'h00, 3'd0});
                wcnt = DW;
            end else if (d <= N && d != int'(m_al)) begin
                if (s) begin
                    p1 = m_so & ~lm(N, int'(m_al));
                    p2 = p1 | hm(N, d);
                    p3 = p2 & ~hm(N, int'(m_al));
                end else begin
                    p1 = m_so & ~hm(N, int'(m_al));
                    p2 = p1 | lm(N, d);
                    p3 = p2 & ~lm(N, int'(m_al));
                end
                m_so = p1;
                q.push_back('{p2, m_al});
                q.push_back('{p3, m_al});
                q.push_back('{p3 | (s ? lm(N, d) : hm(N, d)), 3'(d)});
                wcnt = DW;
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                cmp("sout",   g, 32'(sout_v[g]),  32'(m_so));
                cmp("active", g, 32'(act_v[g]),   32'(m_al));
                cmp("busy",   g, 32'(busy_v[g]),  32'(q.size() > 0));
                cmp("fault",  g, 32'(fault_v[g]), 32'(m_fault));
            end
        end
    end

    task automatic drive(input int g, input logic r, input logic [2:0] d, input logic s, input logic sh);
        rst_v[g]   = r;
        dl_v[g]    = d;
        sign_v[g]  = s;
        short_v[g] = sh;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int g = 0; g < 2; g++) drive(g, 1'b0, 3'd0, 1'b1, 1'b0);
        @(posedge clk);
        chk_en = 1'b1;
        cyc(3);
        cmp("rst_sout",   0, 32'(sout_v[0]),  32'h0);
        cmp("rst_active", 0, 32'(act_v[0]),   32'h0);
        cmp("rst_busy",   0, 32'(busy_v[0]),  32'h0);
        cmp("rst_fault",  0, 32'(fault_v[0]), 32'h0);

        // first closure of load 1, DWELL after the request edge
        drive(0, 1'b1, 3'd1, 1'b1, 1'b0);
        cyc(1); cmp("close_busy", 0, 32'(busy_v[0]), 32'h1);
                cmp("close_open", 0, 32'(sout_v[0]), 32'h00);
        cyc(2); cmp("close_sout", 0, 32'(sout_v[0]), 32'h30);
                cmp("close_act",  0, 32'(act_v[0]),  32'h1);
                cmp("pin_model",  0, 32'(cfg[0].m_so), 32'h30);

        // load 1 -> 2, positive current
        drive(0, 1'b1, 3'd2, 1'b1, 1'b0);
        cyc(1); cmp("sw12_p1", 0, 32'(sout_v[0]), 32'h20);
        cyc(2); cmp("sw12_p2", 0, 32'(sout_v[0]), 32'h28);
        cyc(2); cmp("sw12_p3", 0, 32'(sout_v[0]), 32'h08);
                cmp("sw12_act_hold", 0, 32'(act_v[0]), 32'h1);
        cyc(2); cmp("sw12_p4", 0, 32'(sout_v[0]), 32'h0C);
                cmp("sw12_act", 0, 32'(act_v[0]), 32'h2);
                cmp("sw12_busy", 0, 32'(busy_v[0]), 32'h0);

        // load 2 -> 3, then 3 -> 1 with negative current
        drive(0, 1'b1, 3'd3, 1'b1, 1'b0);
        cyc(8); cmp("sw23_end", 0, 32'(sout_v[0]), 32'h03);
        drive(0, 1'b1, 3'd1, 1'b0, 1'b0);
        cyc(1); cmp("sw31_p1", 0, 32'(sout_v[0]), 32'h01);
                cmp("sw31_a1", 0, 32'(act_v[0]),  32'h3);
        cyc(2); cmp("sw31_p2", 0, 32'(sout_v[0]), 32'h11);
        cyc(2); cmp("sw31_p3", 0, 32'(sout_v[0]), 32'h10);
                cmp("sw31_a3", 0, 32'(act_v[0]),  32'h3);
        cyc(2); cmp("sw31_p4", 0, 32'(sout_v[0]), 32'h30);
                cmp("sw31_a4", 0, 32'(act_v[0]),  32'h1);

        // request and polarity change during MK1 must not disturb the running swap
        drive(0, 1'b1, 3'd2, 1'b1, 1'b0);
        cyc(1); cmp("mk_p1", 0, 32'(sout_v[0]), 32'h20);
        cyc(2); cmp("mk_p2", 0, 32'(sout_v[0]), 32'h28);
        drive(0, 1'b1, 3'd3, 1'b0, 1'b0);
        cyc(2); cmp("mk_p3", 0, 32'(sout_v[0]), 32'h08);
        cyc(2); cmp("mk_p4", 0, 32'(sout_v[0]), 32'h0C);
                cmp("mk_act", 0, 32'(act_v[0]), 32'h2);
        cyc(1); cmp("mk_next", 0, 32'(sout_v[0]), 32'h04);
        cyc(6); cmp("mk_done", 0, 32'(sout_v[0]), 32'h03);
                cmp("mk_done_act", 0, 32'(act_v[0]), 32'h3);

        // reset in BRK2
        drive(0, 1'b1, 3'd1, 1'b1, 1'b0);
        cyc(5); cmp("brk2_sout", 0, 32'(sout_v[0]), 32'h20);
                cmp("brk2_busy", 0, 32'(busy_v[0]), 32'h1);
        drive(0, 1'b0, 3'd2, 1'b1, 1'b0);
        cyc(1); cmp("rst_mid_sout", 0, 32'(sout_v[0]), 32'h0);
                cmp("rst_mid_act",  0, 32'(act_v[0]),  32'h0);
        cyc(2); cmp("rst_hold_busy", 0, 32'(busy_v[0]), 32'h0);
        drive(0, 1'b1, 3'd2, 1'b1, 1'b0);
        cyc(1); cmp("post_rst_busy", 0, 32'(busy_v[0]), 32'h1);
        cyc(2); cmp("post_rst_sout", 0, 32'(sout_v[0]), 32'h0C);

        // short during MK1
        drive(0, 1'b1, 3'd3, 1'b1, 1'b0);
        cyc(3); cmp("sh_mk1", 0, 32'(sout_v[0]), 32'h0A);
        drive(0, 1'b1, 3'd3, 1'b1, 1'b1);
        cyc(1);
        if (FEN) begin
            cmp("sh_sout",  0, 32'(sout_v[0]),  32'h0);
            cmp("sh_fault", 0, 32'(fault_v[0]), 32'h1);
            drive(0, 1'b1, 3'd1, 1'b1, 1'b0);
            cyc(4);
            cmp("sh_hold_sout",  0, 32'(sout_v[0]),  32'h0);
            cmp("sh_hold_fault", 0, 32'(fault_v[0]), 32'h1);
        end else begin
            cmp("sh_ign_sout",  0, 32'(sout_v[0]),  32'h0A);
            cmp("sh_ign_fault", 0, 32'(fault_v[0]), 32'h0);
            drive(0, 1'b1, 3'd3, 1'b1, 1'b0);
            cyc(3);
            cmp("sh_ign_end", 0, 32'(sout_v[0]), 32'h03);
        end
        drive(0, 1'b0, 3'd0, 1'b1, 1'b0);
        cyc(1); cmp("sh_clear", 0, 32'(fault_v[0]), 32'h0);
        cyc(1);

        for (int i = 0; i < 400; i++) begin
            drive(0,
                  FEN ? ($urandom_range(0, 24) != 0) : ($urandom_range(0, 60) != 0),
                  3'($urandom_range(0, 3)),
                  1'($urandom),
                  FEN ? ($urandom_range(0, 79) == 0) : 1'($urandom));
            cyc($urandom_range(1, 4));
        end
        drive(0, 1'b0, 3'd0, 1'b1, 1'b0);
        cyc(2);

        // four loads, dwell 3
        drive(1, 1'b1, 3'd1, 1'b1, 1'b0);
        cyc(1); cmp("c1_busy",  1, 32'(busy_v[1]), 32'h1);
        cyc(3); cmp("c1_close", 1, 32'(sout_v[1]), 32'hC0);
        drive(1, 1'b1, 3'd4, 1'b1, 1'b0);
        cyc(1); cmp("c1_p1", 1, 32'(sout_v[1]), 32'h80);
        cyc(3); cmp("c1_p2", 1, 32'(sout_v[1]), 32'h82);
        cyc(3); cmp("c1_p3", 1, 32'(sout_v[1]), 32'h02);
        cyc(3); cmp("c1_p4", 1, 32'(sout_v[1]), 32'h03);
                cmp("c1_act", 1, 32'(act_v[1]),  32'h4);
        drive(1, 1'b1, 3'd5, 1'b0, 1'b0);
        cyc(6); cmp("c1_ign_sout", 1, 32'(sout_v[1]), 32'h03);
                cmp("c1_ign_busy", 1, 32'(busy_v[1]), 32'h0);

        for (int i = 0; i < 400; i++) begin
            drive(1,
                  FEN ? ($urandom_range(0, 24) != 0) : ($urandom_range(0, 60) != 0),
                  3'($urandom_range(0, 7)),
                  1'($urandom),
                  FEN ? ($urandom_range(0, 79) == 0) : 1'($urandom));
            cyc($urandom_range(1, 5));
        end
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_switch_seq.md
LOAD_SWITCH_SEQ -- requirements
Module: load_switch_seq

Interface
REQ-001 The block SHALL have parameter NLOADS, default 3, number of selectable loads (2..15).
REQ-002 The block SHALL have parameter DWELL, default 2, clock cycles each switch pattern is held during a transition (1..255).
REQ-003 The block SHALL have derived localparam SEL_W = $clog2(NLOADS+1), the width of a load selector.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port DesiredLoad, input, SEL_W bits: target load; 0 = none, k = load k (1..NLOADS).
REQ-007 The block SHALL have port CurrentSign, input, 1 bit: load current polarity; 1 = positive, 0 = negative.
REQ-008 The block SHALL have port Short, input, 1 bit: short-circuit detect, active-high.
REQ-009 The block SHALL have port Sout, output, 2*NLOADS bits: switch drives; load k owns pair H_k = Sout[2*(NLOADS-k)+1] and L_k = Sout[2*(NLOADS-k)], so load 1 is the MSB pair.
REQ-010 The block SHALL have port ActiveLoad, output, SEL_W bits: load whose pair is fully closed, or 0.
REQ-011 The block SHALL have port Busy, output, 1 bit: transition in progress.
REQ-012 The block SHALL have port Fault, output, 1 bit: latched short fault.

Function
REQ-013 States SHALL be OPEN, CLOSE, STEADY, BRK1, MK1, BRK2, DROP, FAULT; every state except OPEN, STEADY and FAULT SHALL be held exactly DWELL cycles, timed by a counter.
REQ-014 In OPEN, Sout SHALL be all 0; a valid nonzero DesiredLoad T SHALL be latched and the state SHALL advance to CLOSE.
REQ-015 Leaving CLOSE SHALL set H_T=L_T=1 and ActiveLoad=T and enter STEADY; first closure SHALL appear DWELL cycles after the request edge.
REQ-016 In STEADY with valid DesiredLoad T != ActiveLoad O and T != 0, the block SHALL latch T and latch CurrentSign as S, then run BRK1 -> MK1 -> BRK2 -> STEADY, with one Sout change per state exit.
REQ-017 For S=1 the sequence SHALL be: clear L_O, set H_T, clear H_O, set L_T. For S=0 it SHALL be: clear H_O, set L_T, clear L_O, set H_T.
REQ-018 In STEADY with DesiredLoad=0, the block SHALL run DROP: clear the first switch per S; DWELL cycles later clear the second and enter OPEN with ActiveLoad=0.
REQ-019 DesiredLoad > NLOADS, or equal to ActiveLoad, SHALL be ignored.
REQ-020 DesiredLoad and CurrentSign changes during a transition SHALL be ignored; a new request SHALL be evaluated only in STEADY or OPEN.
REQ-021 Invariant: exactly one load SHALL have both switches closed in STEADY; during a transition at least one switch SHALL be closed and at most 3 closed.
REQ-022 Busy SHALL be 1 in CLOSE, BRK1, MK1, BRK2 and DROP, and 0 otherwise; ActiveLoad SHALL update on the edge that completes the target pair.
REQ-023 Short=1 on any edge (macro enabled) SHALL drive Sout to 0 and Fault to 1 on that edge and enter FAULT; Short has priority over all requests.
REQ-024 FAULT SHALL be left only by reset.

Reset
REQ-025 rst=0 on a rising edge SHALL force state OPEN, Sout=0, ActiveLoad=0, Busy=0, Fault=0, and clear the counter, including mid-transition.
REQ-026 While rst=0, DesiredLoad SHALL be ignored; OPEN processing SHALL begin on the first edge with rst=1.

Configuration
REQ-027 Macro LSEQ_SHORT_FAULT_EN defined SHALL enable REQ-023 and REQ-024.
REQ-028 Without LSEQ_SHORT_FAULT_EN, Short SHALL be ignored, Fault SHALL be tied to 0, and the FAULT state SHALL be absent.

Structure
REQ-029 Package lsw_pkg SHALL hold the state enum, the sequence-step encoding and the polarity constants POS=1'b1 and NEG=1'b0.
REQ-030 Sub-module lsw_dwell_timer SHALL implement the DWELL down-counter with load/expire signals; the pair-index-to-bit mapping SHALL be a package function.

Verification (NLOADS=3, DWELL=2 unless stated)
REQ-031 Bench SHALL check: release reset, DesiredLoad=1 -> Sout 110000 after 2 cycles; DesiredLoad=2, S=1 -> 100000, 101000, 001000, 001100 at 2-cycle spacing, Busy low at end.
REQ-032 Bench SHALL check: from load 3, S=0, DesiredLoad=1 -> 000001, 010001, 010000, 110000; ActiveLoad=1 only on the last edge.
REQ-033 Bench SHALL check: DesiredLoad changed and CurrentSign flipped during MK1 -> original sequence completes unchanged; new target then starts from STEADY.
REQ-034 Bench SHALL check: rst=0 in BRK2 -> next edge Sout=000000, ActiveLoad=0; Short=1 in MK1 (macro on) -> Sout=000000, Fault=1, held until reset.
REQ-035 Bench SHALL check: NLOADS=4, DWELL=3, load 1 -> 4, S=1 -> 10000000, 10000010, 00000010, 00000011 at 3-cycle spacing; DesiredLoad=5 ignored.
